// File: rtl/ifetch_pkg.sv
// Shared types and widths for the instruction-fetch front end.
package ifetch_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        PCSRC_SEQ  = 2'b00,
        PCSRC_BR   = 2'b01,
        PCSRC_JALR = 2'b10
    } pcsrc_e;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN,
        HALT
    } ifetch_state_e;
endpackage

// File: rtl/ifetch_fifo.sv
// In-order prefetch FIFO of {instr, pc}; flush empties it in one cycle, no write-to-read bypass.
module ifetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign dout   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)   wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: credit-limited imem requests, prefetch FIFO, redirect/discard handling.
// Optional misaligned-target trap and HALT state under IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
    parameter int unsigned     XLEN       = ifetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcplus4,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTarget,
`ifdef IFETCH_MISALIGN_TRAP_EN
    output logic            misalign_err,
`endif
    input  logic [XLEN-1:0] ALUResult
);
    import ifetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifetch_state_e   state, state_nxt;
    logic [XLEN-1:0] fetch_pc, resp_pc, target;
    logic [CW-1:0]   outstanding, out_nxt, discard, discard_nxt, count;
    logic            grant, resp, retire, redirect, push, drop;
    logic [2*XLEN-1:0] head;

    assign retire   = instr_valid && instr_ready;
    assign redirect = retire && (PCSrc == PCSRC_BR || PCSrc == PCSRC_JALR);
    assign grant    = imem_req && imem_gnt;
    // A response with nothing outstanding is a leftover from before reset.
    assign resp     = imem_rvalid && (outstanding != '0);
    assign drop     = redirect || (discard != '0);
    assign push     = resp && !drop;
    assign out_nxt  = outstanding + CW'(grant) - CW'(resp);

    assign imem_req  = (state == RUN) &&
                       (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;

    always_comb begin
        target = (PCSrc == PCSRC_JALR) ? {ALUResult[XLEN-1:1], 1'b0} : PCTarget;
`ifndef IFETCH_MISALIGN_TRAP_EN
        target[1:0] = 2'b00;
`endif
    end

    always_comb begin
        discard_nxt = discard;
        if (redirect)
            discard_nxt = out_nxt;
        else if (resp && discard != '0)
            discard_nxt = discard - 1'b1;
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic bad_tgt;
    assign bad_tgt = redirect && (target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset)        misalign_err <= 1'b0;
        else if (bad_tgt) misalign_err <= 1'b1;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:  state_nxt = RUN;
            RUN: begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                if (bad_tgt)                          state_nxt = HALT;
                else
`endif
                if (redirect && out_nxt != '0)        state_nxt = DRAIN;
            end
            DRAIN: if (discard_nxt == '0)             state_nxt = RUN;
            default:                                  state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            discard     <= discard_nxt;
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
            end else begin
                if (grant) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)  resp_pc  <= resp_pc + XLEN'(4);
            end
        end
    end

    ifetch_fifo #(.W(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .pop   (retire && !redirect),
        .din   ({imem_rdata, resp_pc}),
        .dout  (head),
        .count (count)
    );

    assign instr_valid   = (count != '0);
    assign instr         = head[2*XLEN-1:XLEN];
    assign instr_pc      = head[XLEN-1:0];
    assign instr_pcplus4 = instr_pc + XLEN'(4);
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: random imem/core timing against an architectural PC-stream model.
module tb_ifetch_unit;
    localparam int FIFO_DEPTH = 2;

    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc, instr_pcplus4, PCTarget = '0, ALUResult = '0;
    logic [1:0]  PCSrc = 2'b00;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    ifetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pcplus4(instr_pcplus4),
        .PCSrc(PCSrc), .PCTarget(PCTarget),
`ifdef IFETCH_MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .ALUResult(ALUResult)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pending[$];
    logic [31:0] grant_log[$];

    int checks = 0, errors = 0;
    int cyc = 0, rel = 0, last_due = 0, ret_cnt = 0, first_valid_rel = 0;
    int lat_min = 1, lat_max = 1, gnt_pct = 100, rdy_pct = 100, redir_pct = 0;
    bit seen_valid, prev_hold, redir_want, redir_done;
    logic [1:0]  w_src;
    logic [31:0] w_pt, w_alu, exp_pc, prev_addr, last_ret_pc;

    function automatic logic [31:0] word(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        logic g, rv, ret, rd;
        logic [1:0]  src;
        logic [31:0] pt, alu;
        int lat, due;
        if (instr_valid && !seen_valid) begin seen_valid = 1; first_valid_rel = rel; end
        rv = (pending.size() > 0) && (pending[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? word(pending[0].addr) : $urandom;
        g = ($urandom_range(99) < gnt_pct);
        imem_gnt = g;
        instr_ready = ($urandom_range(99) < rdy_pct);
        ret = instr_valid && instr_ready;
        pt  = $urandom;
        alu = $urandom;
        src = $urandom_range(1) ? 2'b11 : 2'b00;
        rd  = 0;
        if (ret && (redir_want || $urandom_range(99) < redir_pct)) begin
            rd = 1;
            if (redir_want) begin
                src = w_src; pt = w_pt; alu = w_alu;
                redir_want = 0; redir_done = 1;
            end else begin
                src = $urandom_range(1) ? 2'b01 : 2'b10;
`ifdef IFETCH_MISALIGN_TRAP_EN
                pt[1:0] = 2'b00; alu[1] = 1'b0;
`endif
            end
        end
        PCSrc = src; PCTarget = pt; ALUResult = alu;

        if (prev_hold) begin
            chk("hold_req", imem_req, 1);
            chk("hold_addr", imem_addr, prev_addr);
        end
        if (imem_req) chk("addr_align", imem_addr[1:0], 0);
        if (ret) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, word(exp_pc));
            chk("pcplus4", instr_pcplus4, exp_pc + 32'd4);
            last_ret_pc = instr_pc;
            ret_cnt++;
            if (rd) begin
                exp_pc = (src == 2'b10) ? {alu[31:1], 1'b0} : pt;
`ifndef IFETCH_MISALIGN_TRAP_EN
                exp_pc[1:0] = 2'b00;
`endif
            end else exp_pc = exp_pc + 32'd4;
        end
        if (imem_req && g) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pending.push_back('{imem_addr, due});
            grant_log.push_back(imem_addr);
            chk("credit", 32'(pending.size() <= FIFO_DEPTH), 1);
        end
        prev_hold = imem_req && !g && !rd;
        prev_addr = imem_addr;
        @(posedge clk);
        if (rv) void'(pending.pop_front());
        cyc++; rel++;
        @(negedge clk);
    endtask

    // Resets DUT and the imem model together; leaves the DUT in its first post-reset cycle.
    task automatic do_reset();
        reset = 1; imem_gnt = 0; imem_rvalid = 0; instr_ready = 0; PCSrc = 2'b00;
        @(posedge clk); @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("rst_misalign", misalign_err, 0);
`endif
        @(posedge clk); @(negedge clk);
        reset = 0;
        pending.delete(); grant_log.delete();
        exp_pc = 32'h0; last_due = cyc; prev_hold = 0; redir_want = 0; redir_done = 0;
        seen_valid = 0; rel = 0;
        chk("boot_req", imem_req, 0);
    endtask

    task automatic run_until_ret(int target, int budget);
        for (int i = 0; i < budget && ret_cnt < target; i++) step();
        chk("ret_timeout", 32'(ret_cnt >= target), 1);
    endtask

    task automatic redirect_next(logic [1:0] src, logic [31:0] pt, logic [31:0] alu, int budget);
        w_src = src; w_pt = pt; w_alu = alu; redir_want = 1; redir_done = 0;
        for (int i = 0; i < budget && !redir_done; i++) step();
        chk("redir_timeout", 32'(redir_done), 1);
    endtask

    initial begin
        int r0;
        @(negedge clk);

        // Sequential fetch with single-cycle imem.
        do_reset();
        for (int i = 0; i < 20; i++) step();
        chk("grant0", grant_log[0], 32'h0);
        chk("grant1", grant_log[1], 32'h4);
        chk("grant2", grant_log[2], 32'h8);
        chk("first_valid_seen", 32'(seen_valid), 1);
        chk("first_valid_lat", 32'(first_valid_rel >= 2), 1);

        // Core stalled: credit cap stops requests, then resume without loss.
        do_reset();
        rdy_pct = 0;
        for (int i = 0; i < 12; i++) step();
        chk("stall_grants", grant_log.size(), FIFO_DEPTH);
        chk("stall_req", imem_req, 0);
        chk("stall_valid", instr_valid, 1);
        rdy_pct = 100;
        r0 = ret_cnt;
        for (int i = 0; i < 20; i++) step();
        chk("resume_rets", 32'(ret_cnt - r0 >= 6), 1);

        // Branch redirect with a request in flight, latency 3.
        do_reset();
        lat_min = 3; lat_max = 3;
        run_until_ret(ret_cnt + 1, 30);
        redirect_next(2'b01, 32'h100, 32'h0, 10);
        r0 = ret_cnt;
        run_until_ret(r0 + 1, 40);
        chk("br_target_pc", last_ret_pc, 32'h100);

        // JALR redirect on the cycle a response arrives.
        do_reset();
        lat_min = 1; lat_max = 1;
        redirect_next(2'b10, 32'h0, 32'h2001, 20);
        grant_log.delete();
        for (int i = 0; i < 10 && grant_log.size() == 0; i++) step();
        chk("jalr_grant", grant_log.size() > 0 ? grant_log[0] : 32'hX, 32'h2000);
        for (int i = 0; i < 10; i++) step();

        // Reset while draining.
        do_reset();
        lat_min = 3; lat_max = 3;
        run_until_ret(ret_cnt + 1, 30);
        redirect_next(2'b01, 32'h300, 32'h0, 10);
        chk("drain_req", imem_req, 0);
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 10 && grant_log.size() == 0; i++) step();
        chk("restart_addr", grant_log.size() > 0 ? grant_log[0] : 32'hX, 32'h0);

        // Address wrap at the top of the address space.
        do_reset();
        lat_min = 1; lat_max = 1;
        redirect_next(2'b01, 32'hFFFF_FFF8, 32'h0, 20);
        r0 = ret_cnt;
        for (int i = 0; i < 25; i++) step();
        chk("wrap_rets", 32'(ret_cnt - r0 >= 4), 1);

        // Randomised timing and redirects.
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            lat_max = $urandom_range(4, 1);
            gnt_pct = $urandom_range(100, 30);
            rdy_pct = $urandom_range(100, 20);
            redir_pct = $urandom_range(20, 0);
            for (int i = 0; i < 200; i++) step();
        end
        lat_max = 1; gnt_pct = 100; rdy_pct = 100; redir_pct = 0;

`ifdef IFETCH_MISALIGN_TRAP_EN
        // Misaligned target traps into HALT.
        do_reset();
        redirect_next(2'b01, 32'h102, 32'h0, 20);
        for (int i = 0; i < 10; i++) begin
            chk("halt_misalign", misalign_err, 1);
            chk("halt_req", imem_req, 0);
            chk("halt_valid", instr_valid, 0);
            step();
        end
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
